// File: rtl/wb_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : wb_arbiter
//  Brief    : Writeback-stage scheduler. Shares the scalar and vector
//             register-file write ports between the scalar and vector
//             pipelines, parks losing vector writes in one-entry per-file
//             buffers and stalls the scalar pipeline when it cannot be
//             served.
//  Options  : WB_ARB_PERF_EN - adds saturating stall / buffer-fill counters
//  Revision : 1.0 - initial release
// ============================================================================
module wb_arbiter #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_scalar_valid,
  input  logic             i_scalar_reg_req,
  input  logic             i_scalar_vreg_req,
  input  logic             i_vector_reg_req,
  input  logic             i_vector_vreg_req,
  output logic             o_register_wb_sel,
  output logic             o_vector_wb_sel,
  output logic             o_buffer_register_sel,
  output logic             o_buffer_vector_sel,
  output logic             o_buffer_register,
  output logic             o_buffer_vector,
  output logic             o_scalar_grant,
  output logic             o_scalar_stall,
`ifdef WB_ARB_PERF_EN
  output logic [CNT_W-1:0] o_stall_cycles,
  output logic [CNT_W-1:0] o_buffer_fills,
`endif
  output logic             o_wb_idle
);

  // Buffer occupancy, one flop per register file.
  logic r_reg_buf_valid;
  logic r_vec_buf_valid;

  // Per-file request terms.
  logic w_s_reg;
  logic w_s_vec;
  logic w_v_reg;
  logic w_v_vec;
  logic w_grant;

  assign w_s_reg = i_scalar_valid & i_scalar_reg_req;
  assign w_s_vec = i_scalar_valid & i_scalar_vreg_req;
  assign w_v_reg = i_vector_reg_req;
  assign w_v_vec = i_vector_vreg_req;

  // Scalar writeback is atomic: blocked if either requested file's port is
  // busy draining its buffer.
  assign w_grant = i_scalar_valid
                 & ~(w_s_reg & r_reg_buf_valid)
                 & ~(w_s_vec & r_vec_buf_valid);

  assign o_scalar_grant = w_grant;
  assign o_scalar_stall = i_scalar_valid & ~w_grant;
  assign o_wb_idle      = ~r_reg_buf_valid & ~r_vec_buf_valid;

  // Scalar-file port: drain buffer first, then scalar, then live vector.
  always_comb begin
    o_register_wb_sel     = 1'b0;
    o_buffer_register_sel = 1'b0;
    o_buffer_register     = 1'b0;
    if (r_reg_buf_valid) begin
      o_register_wb_sel     = 1'b1;
      o_buffer_register_sel = 1'b1;
      o_buffer_register     = w_v_reg;
    end else if (w_s_reg && w_grant) begin
      o_register_wb_sel     = 1'b0;
      o_buffer_register     = w_v_reg;
    end else if (w_v_reg) begin
      o_register_wb_sel     = 1'b1;
    end
  end

  // Vector-file port: same priority as the scalar-file port.
  always_comb begin
    o_vector_wb_sel     = 1'b0;
    o_buffer_vector_sel = 1'b0;
    o_buffer_vector     = 1'b0;
    if (r_vec_buf_valid) begin
      o_vector_wb_sel     = 1'b1;
      o_buffer_vector_sel = 1'b1;
      o_buffer_vector     = w_v_vec;
    end else if (w_s_vec && w_grant) begin
      o_vector_wb_sel     = 1'b0;
      o_buffer_vector     = w_v_vec;
    end else if (w_v_vec) begin
      o_vector_wb_sel     = 1'b1;
    end
  end

  // A buffer holds data next cycle exactly when it captures this cycle;
  // a full buffer always drains, so capture never overwrites unread data.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_reg_buf_valid <= 1'b0;
      r_vec_buf_valid <= 1'b0;
    end else begin
      r_reg_buf_valid <= o_buffer_register;
      r_vec_buf_valid <= o_buffer_vector;
    end
  end

`ifdef WB_ARB_PERF_EN
  logic [CNT_W-1:0] r_stall_cycles;
  logic [CNT_W-1:0] r_buffer_fills;

  // Saturating performance counters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_stall_cycles <= '0;
      r_buffer_fills <= '0;
    end else begin
      if (o_scalar_stall && (r_stall_cycles != {CNT_W{1'b1}}))
        r_stall_cycles <= r_stall_cycles + 1'b1;
      if ((o_buffer_register || o_buffer_vector) &&
          (r_buffer_fills != {CNT_W{1'b1}}))
        r_buffer_fills <= r_buffer_fills + 1'b1;
    end
  end

  assign o_stall_cycles = r_stall_cycles;
  assign o_buffer_fills = r_buffer_fills;
`else
  // Counter width only matters when the counters are built.
  logic w_unused_cnt_w;
  assign w_unused_cnt_w = (CNT_W > 0);
`endif

endmodule
`default_nettype wire

// File: tb/tb_wb_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_wb_arbiter
//  Brief    : Directed self-checking bench for wb_arbiter.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_wb_arbiter;

  localparam int CNT_W = 4;

  logic clk;
  logic rst_n;
  logic scalar_valid, scalar_reg_req, scalar_vreg_req;
  logic vector_reg_req, vector_vreg_req;
  logic register_wb_sel, vector_wb_sel;
  logic buffer_register_sel, buffer_vector_sel;
  logic buffer_register, buffer_vector;
  logic scalar_grant, scalar_stall, wb_idle;
`ifdef WB_ARB_PERF_EN
  logic [CNT_W-1:0] stall_cycles, buffer_fills;
`endif

  int n_vec  = 0;
  int n_fail = 0;

  wb_arbiter #(.CNT_W(CNT_W)) dut (
    .clk                   (clk),
    .rst_n                 (rst_n),
    .i_scalar_valid        (scalar_valid),
    .i_scalar_reg_req      (scalar_reg_req),
    .i_scalar_vreg_req     (scalar_vreg_req),
    .i_vector_reg_req      (vector_reg_req),
    .i_vector_vreg_req     (vector_vreg_req),
    .o_register_wb_sel     (register_wb_sel),
    .o_vector_wb_sel       (vector_wb_sel),
    .o_buffer_register_sel (buffer_register_sel),
    .o_buffer_vector_sel   (buffer_vector_sel),
    .o_buffer_register     (buffer_register),
    .o_buffer_vector       (buffer_vector),
    .o_scalar_grant        (scalar_grant),
    .o_scalar_stall        (scalar_stall),
`ifdef WB_ARB_PERF_EN
    .o_stall_cycles        (stall_cycles),
    .o_buffer_fills        (buffer_fills),
`endif
    .o_wb_idle             (wb_idle)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Output bundle, MSB first:
  // reg_wb_sel vec_wb_sel buf_reg_sel buf_vec_sel buf_reg buf_vec grant stall idle
  logic [8:0] w_obs;
  assign w_obs = {register_wb_sel, vector_wb_sel, buffer_register_sel,
                  buffer_vector_sel, buffer_register, buffer_vector,
                  scalar_grant, scalar_stall, wb_idle};

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Apply inputs on the falling edge, settle before sampling.
  task automatic drive(input logic sv, input logic sr, input logic svr,
                       input logic vr, input logic vv);
    @(negedge clk);
    scalar_valid    = sv;
    scalar_reg_req  = sr;
    scalar_vreg_req = svr;
    vector_reg_req  = vr;
    vector_vreg_req = vv;
    #2;
  endtask

  initial begin
    rst_n = 1'b0;
    scalar_valid = 0; scalar_reg_req = 0; scalar_vreg_req = 0;
    vector_reg_req = 0; vector_vreg_req = 0;
    repeat (2) @(posedge clk);
    #2;
    chk("reset_state", {23'd0, w_obs}, {23'd0, 9'b000000001});
`ifdef WB_ARB_PERF_EN
    chk("reset_stall_cnt", {28'd0, stall_cycles}, 32'd0);
    chk("reset_fill_cnt",  {28'd0, buffer_fills}, 32'd0);
`endif
    @(negedge clk);
    rst_n = 1'b1;

    // Scalar wins the scalar-file port, vector result parked.
    drive(1, 1, 0, 1, 0);
    chk("reg_fill", {23'd0, w_obs}, {23'd0, 9'b000010101});
    // Buffer drains with no requests.
    drive(0, 0, 0, 0, 0);
    chk("reg_drain", {23'd0, w_obs}, {23'd0, 9'b101000000});
    drive(0, 0, 0, 0, 0);
    chk("reg_empty", {23'd0, w_obs}, {23'd0, 9'b000000001});

    // scalar_valid with no file requests is granted.
    drive(1, 0, 0, 0, 0);
    chk("no_req_grant", {23'd0, w_obs}, {23'd0, 9'b000000101});
    // Both live vector writes, no scalar.
    drive(0, 0, 0, 1, 1);
    chk("live_vec_both", {23'd0, w_obs}, {23'd0, 9'b110000001});

    // Fill, then 5 stalled cycles with drain + refill.
    drive(1, 1, 0, 1, 0);
    chk("reg_fill2", {23'd0, w_obs}, {23'd0, 9'b000010101});
    for (int i = 0; i < 5; i++) begin
      drive(1, 1, 0, 1, 0);
      chk("stall_refill", {23'd0, w_obs}, {23'd0, 9'b101010010});
    end

    // Scalar wants only the vector file while the reg buffer drains.
    drive(1, 0, 1, 0, 0);
    chk("cross_file_grant", {23'd0, w_obs}, {23'd0, 9'b101000100});
`ifdef WB_ARB_PERF_EN
    chk("stall_cnt_5", {28'd0, stall_cycles}, 32'd5);
    chk("fill_cnt_7",  {28'd0, buffer_fills}, 32'd7);
`endif

    // Park a vector-file result.
    drive(1, 0, 1, 0, 1);
    chk("vec_fill", {23'd0, w_obs}, {23'd0, 9'b000001101});
    // Scalar blocked by vector buffer; live vector reg write goes direct.
    drive(1, 1, 1, 1, 0);
    chk("atomic_block", {23'd0, w_obs}, {23'd0, 9'b110100010});
    drive(0, 0, 0, 0, 0);
    chk("idle_again", {23'd0, w_obs}, {23'd0, 9'b000000001});

    // Fill both buffers, keep them full, then reset mid-burst.
    drive(1, 1, 1, 1, 1);
    chk("both_fill", {23'd0, w_obs}, {23'd0, 9'b000011101});
    drive(0, 0, 0, 1, 1);
    chk("both_refill", {23'd0, w_obs}, {23'd0, 9'b111111000});
    @(negedge clk);
    rst_n = 1'b0;
    scalar_valid = 0; scalar_reg_req = 0; scalar_vreg_req = 0;
    vector_reg_req = 0; vector_vreg_req = 0;
    #2;
    chk("midburst_reset", {23'd0, w_obs}, {23'd0, 9'b000000001});
    @(posedge clk);
    #2;
    chk("midburst_reset_cyc", {23'd0, w_obs}, {23'd0, 9'b000000001});
`ifdef WB_ARB_PERF_EN
    chk("midburst_stall_cnt", {28'd0, stall_cycles}, 32'd0);
    chk("midburst_fill_cnt",  {28'd0, buffer_fills}, 32'd0);
`endif
    @(negedge clk);
    rst_n = 1'b1;

`ifdef WB_ARB_PERF_EN
    // Counter saturation: fill + 20 stalls -> both counters at all-ones.
    drive(1, 1, 0, 1, 0);
    for (int i = 0; i < 20; i++) drive(1, 1, 0, 1, 0);
    drive(1, 1, 0, 1, 0);
    chk("stall_sat", {28'd0, stall_cycles}, 32'd15);
    chk("fill_sat",  {28'd0, buffer_fills}, 32'd15);
    drive(1, 1, 0, 1, 0);
    chk("stall_sat_hold", {28'd0, stall_cycles}, 32'd15);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
